// File: rtl/popcount_vec_gen.sv
// popcount_vec_gen: emits an N-bit vector with exactly the requested number of set bits,
// either as a thermometer code or scattered by an LFSR, with the exact count alongside.
module popcount_vec_gen #(
  parameter int N = 31,
  parameter int CW = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [CW-1:0] req_count,
  input  logic          req_mode,
  output logic          vec_valid,
  input  logic          vec_ready,
  output logic [N-1:0]  vec_data,
  output logic [CW-1:0] vec_count,
  output logic          vec_clamped
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic req_ready_q, req_ready_d, vec_valid_q, vec_valid_d, vec_clamped_q, vec_clamped_d;
  logic [N-1:0] vec_data_q, vec_data_d;
  logic [CW-1:0] vec_count_q, vec_count_d, ptr_q, ptr_d, placed_q, placed_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [CW-1:0] tgt, need, free;
  logic clamp, set;
  always_comb begin
    clamp = {1'b0, req_count} > (CW+1)'(N);
    tgt = clamp ? CW'(N) : req_count;
    need = vec_count_q - placed_q;
    free = CW'(N) - ptr_q;
    // force a one once the remaining free slots exactly match the ones still owed
    set = (need != '0) && ((need == free) || lfsr_q[0]);
    state_d = state_q;
    req_ready_d = req_ready_q;
    vec_valid_d = vec_valid_q;
    vec_data_d = vec_data_q;
    vec_count_d = vec_count_q;
    vec_clamped_d = vec_clamped_q;
    ptr_d = ptr_q;
    placed_d = placed_q;
    lfsr_d = lfsr_q;
    if (state_q == IDLE && req_valid) begin
      state_d = req_mode ? FILL : HOLD;
      req_ready_d = 1'b0;
      vec_valid_d = !req_mode;
      vec_data_d = req_mode ? '0 : ~({N{1'b1}} << tgt);
      vec_count_d = tgt;
      vec_clamped_d = clamp;
      ptr_d = '0;
      placed_d = '0;
    end
    if (state_q == FILL) begin
      vec_data_d = vec_data_q | (N'(set) << ptr_q);
      placed_d = placed_q + CW'(set);
      ptr_d = ptr_q + CW'(1);
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      state_d = (ptr_q == CW'(N - 1)) ? HOLD : FILL;
      vec_valid_d = ptr_q == CW'(N - 1);
    end
    if (state_q == HOLD && vec_ready) begin
      state_d = IDLE;
      vec_valid_d = 1'b0;
      req_ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_ready_q <= 1'b1;
      vec_valid_q <= 1'b0;
      vec_data_q <= '0;
      vec_count_q <= '0;
      vec_clamped_q <= 1'b0;
      ptr_q <= '0;
      placed_q <= '0;
      lfsr_q <= SEED;
    end else begin
      state_q <= state_d;
      req_ready_q <= req_ready_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q <= vec_data_d;
      vec_count_q <= vec_count_d;
      vec_clamped_q <= vec_clamped_d;
      ptr_q <= ptr_d;
      placed_q <= placed_d;
      lfsr_q <= lfsr_d;
    end
  end
  assign req_ready = req_ready_q;
  assign vec_valid = vec_valid_q;
  assign vec_data = vec_data_q;
  assign vec_count = vec_count_q;
  assign vec_clamped = vec_clamped_q;
endmodule

// File: tb/tb_popcount_vec_gen.sv
// tb_popcount_vec_gen: directed vectors for a 31-bit and a 20-bit generator, with an
// LFSR reference model for scattered patterns.
module tb_popcount_vec_gen;
  logic clk, rst_n, rv_a, rv_b, req_mode, vec_ready;
  logic [4:0] req_count;
  logic rr_a, rr_b, vv_a, vv_b, cl_a, cl_b;
  logic [30:0] vd_a;
  logic [19:0] vd_b;
  logic [4:0] vc_a, vc_b;
  int n_chk = 0, n_fail = 0;
  logic [15:0] lm_a, lm_b;

  popcount_vec_gen #(.N(31), .CW(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rr_a), .req_count(req_count),
    .req_mode(req_mode), .vec_valid(vv_a), .vec_ready(vec_ready), .vec_data(vd_a),
    .vec_count(vc_a), .vec_clamped(cl_a));
  popcount_vec_gen #(.N(20), .CW(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rr_b), .req_count(req_count),
    .req_mode(req_mode), .vec_valid(vv_b), .vec_ready(vec_ready), .vec_data(vd_b),
    .vec_count(vc_b), .vec_clamped(cl_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sel; bit m; int c; int lat; int cnt; bit clp; bit fixed; logic [63:0] data;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] scatter(input int n, input int tgt, input logic [15:0] l_in,
                                          output logic [15:0] l_out);
    logic [15:0] l;
    logic [63:0] v;
    int placed;
    l = l_in; v = '0; placed = 0;
    for (int p = 0; p < n; p++) begin
      if ((tgt - placed) != 0 && ((tgt - placed) == (n - p) || l[0])) begin
        v[p] = 1'b1;
        placed++;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    l_out = l;
    return v;
  endfunction

  task automatic run_req(input bit sel, input bit m, input int c, output int lat,
                         output logic [63:0] d, output int cnt, output logic clp);
    @(negedge clk);
    chk("req_ready_idle", 64'(sel ? rr_b : rr_a), 64'd1);
    req_mode = m; req_count = 5'(c);
    if (sel) rv_b = 1'b1; else rv_a = 1'b1;
    @(posedge clk); #1;
    rv_a = 1'b0; rv_b = 1'b0;
    lat = 1;
    while (!(sel ? vv_b : vv_a) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    d = sel ? 64'(vd_b) : 64'(vd_a);
    cnt = sel ? int'(vc_b) : int'(vc_a);
    clp = sel ? cl_b : cl_a;
  endtask

  task automatic drain(input bit sel);
    @(negedge clk);
    vec_ready = 1'b1;
    @(posedge clk); #1;
    vec_ready = 1'b0;
    chk("drain_valid", 64'(sel ? vv_b : vv_a), 64'd0);
    chk("drain_ready", 64'(sel ? rr_b : rr_a), 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(rr_a), 64'd1);
    chk("rst_vec_valid", 64'(vv_a), 64'd0);
    chk("rst_vec_data", 64'(vd_a), 64'd0);
    chk("rst_vec_count", 64'(vc_a), 64'd0);
    chk("rst_vec_clamped", 64'(cl_a), 64'd0);
  endtask

  initial begin
    int lat, cnt;
    logic [63:0] d, exp_d, vec_a0;
    logic clp;
    tbl[0] = '{0, 0, 5, 1, 5, 0, 1, 64'h1F};
    tbl[1] = '{0, 0, 0, 1, 0, 0, 1, 64'h0};
    tbl[2] = '{0, 0, 31, 1, 31, 0, 1, 64'h7FFFFFFF};
    tbl[3] = '{0, 1, 0, 32, 0, 0, 1, 64'h0};
    tbl[4] = '{0, 1, 1, 32, 1, 0, 0, 64'h0};
    tbl[5] = '{0, 1, 17, 32, 17, 0, 0, 64'h0};
    tbl[6] = '{0, 1, 31, 32, 31, 0, 1, 64'h7FFFFFFF};
    tbl[7] = '{1, 0, 25, 1, 20, 1, 1, 64'hFFFFF};
    tbl[8] = '{1, 1, 25, 21, 20, 1, 1, 64'hFFFFF};
    rst_n = 1'b1; rv_a = 1'b0; rv_b = 1'b0; req_mode = 1'b0; vec_ready = 1'b0; req_count = '0;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    lm_a = 16'hACE1; lm_b = 16'hACE1;

    foreach (tbl[i]) begin
      run_req(tbl[i].sel, tbl[i].m, tbl[i].c, lat, d, cnt, clp);
      exp_d = tbl[i].data;
      if (tbl[i].m) begin
        if (tbl[i].sel) exp_d = scatter(20, tbl[i].cnt, lm_b, lm_b);
        else exp_d = scatter(31, tbl[i].cnt, lm_a, lm_a);
        if (tbl[i].fixed) exp_d = tbl[i].data;
      end
      chk($sformatf("latency[%0d]", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec_count[%0d]", i), 64'(cnt), 64'(tbl[i].cnt));
      chk($sformatf("vec_clamped[%0d]", i), 64'(clp), 64'(tbl[i].clp));
      chk($sformatf("popcount[%0d]", i), 64'($countones(d)), 64'(tbl[i].cnt));
      chk($sformatf("vec_data[%0d]", i), d, exp_d);
      drain(tbl[i].sel);
    end

    run_req(0, 0, 9, lat, d, cnt, clp);
    chk("bp_data0", d, 64'h1FF);
    @(negedge clk);
    rv_a = 1'b1; req_count = 5'd3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_data", 64'(vd_a), 64'h1FF);
      chk("bp_count", 64'(vc_a), 64'd9);
      chk("bp_req_ready", 64'(rr_a), 64'd0);
      chk("bp_valid", 64'(vv_a), 64'd1);
    end
    rv_a = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    lm_a = 16'hACE1; lm_b = 16'hACE1;

    run_req(0, 1, 17, lat, vec_a0, cnt, clp);
    chk("rerun_first_model", vec_a0, scatter(31, 17, lm_a, lm_a));
    drain(0);
    @(negedge clk);
    req_mode = 1'b1; req_count = 5'd17; rv_a = 1'b1;
    @(posedge clk); #1;
    rv_a = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    lm_a = 16'hACE1;
    run_req(0, 1, 17, lat, d, cnt, clp);
    chk("rerun_latency", 64'(lat), 64'd32);
    chk("rerun_vec_data", d, vec_a0);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
